avalon_burst_slave_mem: RTL and testbench

- Synthesizable Avalon-MM burst slave with a word-addressed on-chip memory array.
- Acts as the responder end of the avalon_mem master interface: accepts avm_* write and read bursts of 1–4 beats and returns read data with readdatavalid after a fixed latency.
- Used as the memory model in ao486 benches and as a small on-chip RAM slave on the system bus.

---
 rtl/avalon_burst_slave_pkg.sv | 27 ++
 rtl/avs_mem_array.sv | 39 +++
 rtl/avalon_burst_slave_mem.sv | 175 +++++++++++++++++
 tb/tb_avalon_burst_slave_mem.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_burst_slave_pkg.sv
// Shared types and constants for the Avalon-MM burst slave memory.
// Holds the FSM state encoding, burst limit and stall-injection LFSR constants.
package avalon_burst_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RLAT   = 2'd2,
        RDATA  = 2'd3
    } state_t;

    localparam logic [2:0]  MAX_BURST      = 3'd4;
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [15:0] LFSR_SEED      = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    // Out-of-range burst counts collapse to a single beat.
    function automatic logic [2:0] burst_beats(input logic [2:0] bc);
        return ((bc == 3'd0) || (bc > MAX_BURST)) ? 3'd1 : bc;
    endfunction

endpackage

// File: rtl/avs_mem_array.sv
// Single-port byte-enabled word RAM with a registered read port.
// The storage array has no reset so it can map onto block RAM.
module avs_mem_array
    import avalon_burst_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            be,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Output register holds its value between read beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/avalon_burst_slave_mem.sv
// Avalon-MM burst slave (1-4 beats) in front of a word-addressed on-chip RAM.
// Optional macro AVS_WAIT_INJECT_EN adds LFSR-driven pseudo-random waitrequest stalls.
module avalon_burst_slave_mem
    import avalon_burst_slave_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] avs_address,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    input  logic [2:0]  avs_burstcount,
    input  logic        avs_write,
    input  logic        avs_read,
    output logic        avs_waitrequest,
    output logic        avs_readdatavalid,
    output logic [31:0] avs_readdata,
    output logic        proto_err
);

    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

    state_t                state, state_n;
    logic [DEPTH_LOG2-1:0] idx, idx_n;
    logic [2:0]            rem, rem_n;
    logic [2:0]            cnt, cnt_n;
    logic                  perr_n;
    logic                  ready;
    logic                  rvalid;
    logic                  inject_stall;
    logic                  wr_en, rd_en;
    logic [DEPTH_LOG2-1:0] mem_addr;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  bc_bad;
    logic [2:0]            beats;
    logic                  accept_wr, accept_rd;
    logic                  unused_addr_bits;

    assign word_idx         = avs_address[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{avs_address[31:DEPTH_LOG2+2], avs_address[1:0]};
    assign bc_bad           = (avs_burstcount == 3'd0) || (avs_burstcount > MAX_BURST);
    assign beats            = burst_beats(avs_burstcount);

`ifdef AVS_WAIT_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign inject_stall = (lfsr[1:0] == 2'b00);
`else
    assign inject_stall = 1'b0;
`endif

    // Handshake: a request or write beat is accepted on a rising edge where
    // avs_read/avs_write is high and avs_waitrequest is low; read data is
    // pushed with avs_readdatavalid and cannot be back-pressured.
    assign avs_waitrequest = !ready || (state == RLAT) || (state == RDATA) || inject_stall;
    assign accept_wr       = avs_write && !avs_waitrequest;
    assign accept_rd       = avs_read && !avs_waitrequest;

    assign avs_readdatavalid = rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rem       <= '0;
            cnt       <= '0;
            proto_err <= 1'b0;
            ready     <= 1'b0;
            rvalid    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            rem       <= rem_n;
            cnt       <= cnt_n;
            proto_err <= perr_n;
            ready     <= 1'b1;
            rvalid    <= (state == RDATA);
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        rem_n    = rem;
        cnt_n    = cnt;
        perr_n   = proto_err;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        mem_addr = idx;

        case (state)
            IDLE: begin
                if (accept_wr) begin
                    wr_en    = 1'b1;
                    mem_addr = word_idx;
                    if (avs_read || bc_bad) begin
                        perr_n = 1'b1;
                    end
                    if (beats != 3'd1) begin
                        state_n = WBURST;
                        rem_n   = beats - 3'd1;
                        idx_n   = word_idx + 1'b1;
                    end
                end else if (accept_rd) begin
                    idx_n = word_idx;
                    rem_n = beats;
                    if (bc_bad) begin
                        perr_n = 1'b1;
                    end
                    if (READ_LATENCY == 1) begin
                        state_n = RDATA;
                    end else begin
                        state_n = RLAT;
                        cnt_n   = LAT_INIT;
                    end
                end
            end
            WBURST: begin
                if (avs_read) begin
                    perr_n = 1'b1;
                end
                if (accept_wr) begin
                    wr_en = 1'b1;
                    idx_n = idx + 1'b1;
                    rem_n = rem - 3'd1;
                    if (rem == 3'd1) begin
                        state_n = IDLE;
                    end
                end
            end
            RLAT: begin
                // RDATA is entered one edge before the first beat is driven.
                if (cnt == 3'd1) begin
                    state_n = RDATA;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            RDATA: begin
                rd_en = 1'b1;
                idx_n = idx + 1'b1;
                rem_n = rem - 3'd1;
                if (rem == 3'd1) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    avs_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (mem_addr),
        .wdata (avs_writedata),
        .be    (avs_byteenable),
        .rdata (avs_readdata)
    );

endmodule

// File: tb/tb_avalon_burst_slave_mem.sv
// Self-checking bench for avalon_burst_slave_mem: word-array memory model, cycle-stamped
// read expectations, and one negedge compare process; also builds with AVS_WAIT_INJECT_EN.
module tb_avalon_burst_slave_mem;

    localparam int DL    = 10;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << DL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] avs_address = '0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [2:0]  avs_burstcount = '0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic        avs_waitrequest;
    logic        avs_readdatavalid;
    logic [31:0] avs_readdata;
    logic        proto_err;

    always #5 clk = ~clk;

    avalon_burst_slave_mem #(.DEPTH_LOG2(DL), .READ_LATENCY(RL)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .avs_address       (avs_address),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_write         (avs_write),
        .avs_read          (avs_read),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_readdata      (avs_readdata),
        .proto_err         (proto_err)
    );

    // Behavioural model: plain word array plus cycle-stamped expected read beats.
    logic [31:0] mem_model [DEPTH];
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          rd_last_cyc = 0;
    logic        perr_exp = 1'b0;
    logic [31:0] last_rd = '0;
    bit          after_rst = 1'b0;
    int          stall_seen = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle the outputs are meaningful.
    always @(negedge clk) begin
        logic exp_wait;
        if (!rst_n) begin
            check("rst_wait", avs_waitrequest, 1);
            check("rst_rvalid", avs_readdatavalid, 0);
            check("rst_rdata", avs_readdata, 0);
            check("rst_perr", proto_err, 0);
            after_rst = 1'b1;
            last_rd   = '0;
        end else begin
            exp_wait  = after_rst || (rd_last_cyc > cyc);
            after_rst = 1'b0;
`ifdef AVS_WAIT_INJECT_EN
            if (exp_wait) check("wait_busy", avs_waitrequest, 1);
            else if (avs_waitrequest) stall_seen++;
`else
            check("wait", avs_waitrequest, exp_wait);
`endif
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_beat: got none expected %h at cycle %0d", exp_q[0], exp_cyc_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                check("rvalid_beat", avs_readdatavalid, 1);
                check("rdata_beat", avs_readdata, exp_q[0]);
                last_rd = exp_q[0];
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end else begin
                check("rvalid_idle", avs_readdatavalid, 0);
                check("rdata_hold", avs_readdata, last_rd);
            end
            check("proto_err", proto_err, perr_exp);
        end
    end

    // Waits for acceptance; returns the number of the accepting edge.
    task automatic wait_accept(output int acc_edge, output bit ok);
        ok = 1'b0;
        acc_edge = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                acc_edge = cyc + 1;
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: got waitrequest stuck high expected acceptance (cycle %0d)", cyc);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] bc,
                            input logic [31:0] d [4], input logic [3:0] b [4], input bit with_read);
        int  beats;
        int  acc;
        int  w;
        bit  ok;
        beats = (bc == 3'd0 || bc > 3'd4) ? 1 : int'(bc);
        for (int i = 0; i < beats; i++) begin
            if (i > 0 && $urandom_range(0, 2) == 0) begin
                avs_write = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            avs_write      = 1'b1;
            avs_read       = with_read && (i == 0);
            avs_address    = addr + 32'(4 * i);
            avs_burstcount = bc;
            avs_writedata  = d[i];
            avs_byteenable = b[i];
            wait_accept(acc, ok);
            if (!ok) break;
            w = (int'(addr[DL+1:2]) + i) % DEPTH;
            for (int k = 0; k < 4; k++)
                if (b[i][k]) mem_model[w][8*k +: 8] = d[i][8*k +: 8];
            if (i == 0 && (with_read || beats != int'(bc))) perr_exp = 1'b1;
        end
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] bc, output int acc);
        int beats;
        bit ok;
        beats          = (bc == 3'd0 || bc > 3'd4) ? 1 : int'(bc);
        avs_read       = 1'b1;
        avs_address    = addr;
        avs_burstcount = bc;
        wait_accept(acc, ok);
        avs_read = 1'b0;
        if (ok) begin
            for (int i = 0; i < beats; i++) begin
                exp_q.push_back(mem_model[(int'(addr[DL+1:2]) + i) % DEPTH]);
                exp_cyc_q.push_back(acc + RL + i);
            end
            rd_last_cyc = acc + RL + beats - 1;
            if (beats != int'(bc)) perr_exp = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd [4];
        logic [3:0]  wb [4];
        int          acc;
        logic [31:0] a;

        // Reset and ready-flop release.
        repeat (3) @(negedge clk);
        check("lit_rst_wait", avs_waitrequest, 1);
        check("lit_rst_rvalid", avs_readdatavalid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("lit_ready_hold", avs_waitrequest, 1);
        @(negedge clk);
`ifndef AVS_WAIT_INJECT_EN
        check("lit_idle_ready", avs_waitrequest, 0);
`endif
        check("lit_perr0", proto_err, 0);
        @(posedge clk);
        #1;

        // Fill whole memory so every later read has a known value.
        for (int n = 0; n < DEPTH / 4; n++) begin
            for (int i = 0; i < 4; i++) begin
                wd[i] = $urandom;
                wb[i] = 4'hF;
            end
            do_write(32'(n * 16), 3'd4, wd, wb, 1'b0);
        end

        // Directed burst at 0x100 with a masked second beat over 0xFFFFFFFF.
        wd[0] = 32'hFFFF_FFFF; wb[0] = 4'hF;
        do_write(32'h104, 3'd1, wd, wb, 1'b0);
        wd[0] = 32'h89AB_CDEF; wb[0] = 4'b1111;
        wd[1] = 32'h0023_4567; wb[1] = 4'b0101;
        do_write(32'h100, 3'd2, wd, wb, 1'b0);
        check("model_w64", mem_model[64], 32'h89AB_CDEF);
        check("model_w65", mem_model[65], 32'hFF23_FF67);
        do_read(32'h100, 3'd2, acc);
        @(negedge clk);
        @(negedge clk);
        check("lit_lat_early", avs_readdatavalid, 0);
        @(negedge clk);
        check("lit_beat0_valid", avs_readdatavalid, 1);
        check("lit_beat0_data", avs_readdata, 32'h89AB_CDEF);
        @(negedge clk);
        check("lit_beat1_valid", avs_readdatavalid, 1);
        check("lit_beat1_data", avs_readdata, 32'hFF23_FF67);
        @(posedge clk);
        #1;

        // Read burst wrapping over the top word; upper address bits are ignored.
        do_read(32'hFFFF_FFFC, 3'd4, acc);

        // Burstcount 0 acts as one beat and flags an error.
        wd[0] = 32'h1357_9BDF; wd[1] = 32'h2468_ACE0; wb[0] = 4'hF; wb[1] = 4'hF;
        do_write(32'h300, 3'd0, wd, wb, 1'b0);
        do_read(32'h300, 3'd2, acc);
        repeat (5) @(negedge clk);
        check("lit_perr_bc0", proto_err, 1);
        @(posedge clk);
        #1;

        // Reset during beat 2 of a 4-beat read.
        do_read(32'h200, 3'd4, acc);
        repeat (RL + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("lit_async_rvalid", avs_readdatavalid, 0);
        check("lit_async_rdata", avs_readdata, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        rd_last_cyc = 0;
        perr_exp    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("lit_perr_cleared", proto_err, 0);
        @(posedge clk);
        #1;
        do_read(32'h200, 3'd4, acc);

        // Read and write together: write wins, error flag sticks.
        wd[0] = 32'hCAFE_F00D; wb[0] = 4'hF;
        do_write(32'h400, 3'd1, wd, wb, 1'b1);
        check("model_w256", mem_model[256], 32'hCAFE_F00D);
        do_read(32'h400, 3'd1, acc);
        repeat (4) @(negedge clk);
        check("lit_perr_rw", proto_err, 1);
        @(posedge clk);
        #1;

        // Randomized writes and reads.
        for (int n = 0; n < 100; n++) begin
            a = 32'($urandom_range(0, 4 * DEPTH - 1));
            for (int i = 0; i < 4; i++) begin
                wd[i] = $urandom;
                wb[i] = 4'($urandom_range(0, 15));
            end
            acc = $urandom_range(1, 4);
            do_write(a, 3'(acc), wd, wb, 1'b0);
            do_read(a, 3'($urandom_range(1, 4)), acc);
            if ($urandom_range(0, 1) == 1)
                do_read(32'($urandom), 3'($urandom_range(1, 4)), acc);
        end

        repeat (12) @(negedge clk);
        check("drain", 32'(exp_q.size()), 0);
`ifdef AVS_WAIT_INJECT_EN
        check("stall_seen", 32'(stall_seen > 0), 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
